// File: rtl/ls_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM state
// encoding and the default data memory size.
package ls_pkg;

    // Data memory size in bytes; a word access ending at or past this is rejected.
    localparam int unsigned MEM_BYTES_DEFAULT = 32'd4096;

    // Access size as presented on ls_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } ls_size_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ERR    = 3'd1,
        ST_RD     = 3'd2,
        ST_WR     = 3'd3,
        ST_RMW_RD = 3'd4,
        ST_RMW_WR = 3'd5,
        ST_DONE   = 3'd6
    } ls_state_e;

    // Word-aligned memory address for a byte address.
    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ls_lane_mux.sv
// Big-endian lane steering for the load/store unit.
// Loads: pick the addressed byte/half out of the memory word and extend it.
// Sub-word stores: splice the store data into the addressed lane of the word
// that was read back, so the full-word write leaves the other lanes intact.
module ls_lane_mux
    import ls_pkg::*;
(
    input  logic [1:0]  offset,
    input  ls_size_e    size,
    input  logic        is_signed,
    input  logic [31:0] mem_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes (offset 0 is the MSB lane).
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (offset)
            2'd0:    byte_s = mem_word[31:24];
            2'd1:    byte_s = mem_word[23:16];
            2'd2:    byte_s = mem_word[15:8];
            2'd3:    byte_s = mem_word[7:0];
            default: byte_s = 8'h00;
        endcase
        if (offset[1] == 1'b0) begin
            half_s = mem_word[31:16];
        end else begin
            half_s = mem_word[15:0];
        end
    end

    // Extend the selected lane to a 32-bit load result.
    always_comb begin
        ld_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                if (is_signed) begin
                    ld_data = {{24{byte_s[7]}}, byte_s};
                end else begin
                    ld_data = {24'h00_0000, byte_s};
                end
            end
            SZ_HALF: begin
                if (is_signed) begin
                    ld_data = {{16{half_s[15]}}, half_s};
                end else begin
                    ld_data = {16'h0000, half_s};
                end
            end
            SZ_WORD: ld_data = mem_word;
            default: ld_data = 32'h0000_0000;
        endcase
    end

    // Replace the target lane of the read-back word with the store data.
    always_comb begin
        merge_word = mem_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merge_word[31:24] = st_data[7:0];
                    2'd1:    merge_word[23:16] = st_data[7:0];
                    2'd2:    merge_word[15:8]  = st_data[7:0];
                    2'd3:    merge_word[7:0]   = st_data[7:0];
                    default: merge_word        = mem_word;
                endcase
            end
            SZ_HALF: begin
                if (offset[1] == 1'b0) begin
                    merge_word[31:16] = st_data[15:0];
                end else begin
                    merge_word[15:0] = st_data[15:0];
                end
            end
            SZ_WORD: merge_word = st_data;
            default: merge_word = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the CPU control unit and a byte-addressed,
// big-endian data memory that always transfers whole words.
// One request at a time; sub-word stores run as read-modify-write; misaligned,
// illegal-size or out-of-range requests finish with err and touch no memory.
module load_store_unit
    import ls_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ls_rdata,
    output logic        dm_cs,
    output logic        dm_rd,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    // FSM and request latches
    ls_state_e   state_q,  state_d;
    logic [1:0]  offset_q, offset_d;
    ls_size_e    size_q,   size_d;
    logic        signed_q, signed_d;
    logic [31:0] wdata_q,  wdata_d;

    // Output registers
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        err_q,    err_d;
    logic        dm_cs_q,  dm_cs_d;
    logic        dm_rd_q,  dm_rd_d;
    logic        dm_wr_q,  dm_wr_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic [31:0] dm_addr_q,  dm_addr_d;
    logic [31:0] dm_din_q,   dm_din_d;

    // Request classification and lane steering
    ls_size_e    req_size_s;
    logic [32:0] range_end_s;
    logic        align_bad_s;
    logic        range_bad_s;
    logic        req_bad_s;
    logic [31:0] ld_data_s;
    logic [31:0] merge_s;

    assign req_size_s  = ls_size_e'(ls_size);
    // Last byte touched by the word access, widened so it cannot wrap.
    assign range_end_s = {1'b0, word_align(ls_addr)} + 33'd3;
    assign range_bad_s = (range_end_s >= MEM_LIMIT);
    assign req_bad_s   = align_bad_s | range_bad_s;

    // Alignment / size legality of the incoming request.
    always_comb begin
        align_bad_s = 1'b0;
        case (req_size_s)
            SZ_BYTE: align_bad_s = 1'b0;
            SZ_HALF: align_bad_s = ls_addr[0];
            SZ_WORD: align_bad_s = (ls_addr[1:0] != 2'b00);
            default: align_bad_s = 1'b1;
        endcase
    end

    ls_lane_mux u_lane_mux (
        .offset     (offset_q),
        .size       (size_q),
        .is_signed  (signed_q),
        .mem_word   (dm_dout),
        .st_data    (wdata_q),
        .ld_data    (ld_data_s),
        .merge_word (merge_s)
    );

    // Next state, request latching and data-path register updates.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        size_d     = size_q;
        signed_d   = signed_q;
        wdata_d    = wdata_q;
        ls_rdata_d = ls_rdata_q;
        dm_addr_d  = dm_addr_q;
        dm_din_d   = dm_din_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    offset_d = ls_addr[1:0];
                    size_d   = req_size_s;
                    signed_d = ls_signed;
                    wdata_d  = ls_wdata;
                    if (req_bad_s) begin
                        state_d = ST_ERR;
                    end else begin
                        // Address is held from here until the access finishes.
                        dm_addr_d = word_align(ls_addr);
                        if (!ls_wr) begin
                            state_d = ST_RD;
                        end else if (req_size_s == SZ_WORD) begin
                            state_d  = ST_WR;
                            dm_din_d = ls_wdata;
                        end else begin
                            state_d = ST_RMW_RD;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR:    state_d = ST_IDLE;
            ST_RD: begin
                ls_rdata_d = ld_data_s;
                state_d    = ST_DONE;
            end
            ST_WR:     state_d = ST_DONE;
            ST_RMW_RD: begin
                // The write-data register doubles as the merge register.
                dm_din_d = merge_s;
                state_d  = ST_RMW_WR;
            end
            ST_RMW_WR: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Status and memory strobes decoded from the state being entered, so they
    // come straight out of flops.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE) || (state_d == ST_ERR);
        err_d   = (state_d == ST_ERR);
        dm_rd_d = (state_d == ST_RD) || (state_d == ST_RMW_RD);
        dm_wr_d = (state_d == ST_WR) || (state_d == ST_RMW_WR);
        dm_cs_d = dm_rd_d | dm_wr_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            offset_q   <= 2'b00;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dm_cs_q    <= 1'b0;
            dm_rd_q    <= 1'b0;
            dm_wr_q    <= 1'b0;
            ls_rdata_q <= 32'h0000_0000;
            dm_addr_q  <= 32'h0000_0000;
            dm_din_q   <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dm_cs_q    <= dm_cs_d;
            dm_rd_q    <= dm_rd_d;
            dm_wr_q    <= dm_wr_d;
            ls_rdata_q <= ls_rdata_d;
            dm_addr_q  <= dm_addr_d;
            dm_din_q   <= dm_din_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign ls_rdata = ls_rdata_q;
    assign dm_rd    = dm_rd_q;
    assign dm_addr  = dm_addr_q;
    assign dm_din   = dm_din_q;
    // Gate select/write with reset so an aborted RMW never lands in memory.
    assign dm_cs    = dm_cs_q & ~reset;
    assign dm_wr    = dm_wr_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory, a reference
// model of the request rules, a per-cycle compare process and directed tests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic        ls_signed;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        busy, done, err;
    logic [31:0] ls_rdata;
    logic        dm_cs, dm_rd, dm_wr;
    logic [31:0] dm_addr, dm_din, dm_dout;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset), .req(req), .ls_wr(ls_wr), .ls_size(ls_size),
        .ls_signed(ls_signed), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .busy(busy), .done(done), .err(err), .ls_rdata(ls_rdata),
        .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr),
        .dm_din(dm_din), .dm_dout(dm_dout)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory (big-endian byte array) ----------------
    logic [7:0]  mem [0:4095];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'h0;
    logic [31:0] pl_data = 32'h0;
    logic [11:0] mb;
    assign mb      = {dm_addr[11:2], 2'b00};
    assign dm_dout = {mem[mb], mem[mb + 12'd1], mem[mb + 12'd2], mem[mb + 12'd3]};

    always @(posedge clk) begin
        if (pl_en) begin
            for (int i = 0; i < 4; i++) mem[pl_addr[11:0] + 12'(i)] <= pl_data[31 - 8*i -: 8];
        end else if (dm_cs && dm_wr) begin
            for (int i = 0; i < 4; i++) mem[mb + 12'(i)] <= dm_din[31 - 8*i -: 8];
        end
    end

    function automatic logic [31:0] tb_word(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {mem[b], mem[b + 12'd1], mem[b + 12'd2], mem[b + 12'd3]};
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:4095];
    int          m_phase = 0;
    int          m_lat   = 0;
    int          m_rdp   = 0;
    int          m_wrp   = 0;
    logic        m_err   = 1'b0;
    logic        m_load  = 1'b0;
    logic [31:0] m_waddr = 32'h0;
    logic [31:0] m_din   = 32'h0;
    logic [31:0] m_ld    = 32'h0;
    logic [31:0] exp_rdata = 32'h0;

    function automatic logic ref_bad(input logic [31:0] a, input logic [1:0] sz);
        longint last;
        last = longint'({32'h0, a[31:2], 2'b00}) + 64'sd3;
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
               || (last >= 64'sd4096);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [11:0] b;
        logic [7:0]  v8;
        logic [15:0] v16;
        b   = a[11:0];
        v8  = ref_mem[b];
        v16 = {ref_mem[b], ref_mem[b + 12'd1]};
        if (sz == 2'b00) return sg ? {{24{v8[7]}}, v8} : {24'h0, v8};
        if (sz == 2'b01) return sg ? {{16{v16[15]}}, v16} : {16'h0, v16};
        b = {a[11:2], 2'b00};
        return {ref_mem[b], ref_mem[b + 12'd1], ref_mem[b + 12'd2], ref_mem[b + 12'd3]};
    endfunction

    function automatic logic [31:0] ref_store_word(input logic [31:0] a, input logic [1:0] sz,
                                                   input logic [31:0] wd);
        logic [7:0]  by [4];
        logic [11:0] b;
        int          off;
        b   = {a[11:2], 2'b00};
        off = int'(a[1:0]);
        for (int i = 0; i < 4; i++) by[i] = ref_mem[b + 12'(i)];
        if (sz == 2'b00) begin
            by[off] = wd[7:0];
        end else if (sz == 2'b01) begin
            if (off < 3) begin
                by[off]     = wd[15:8];
                by[off + 1] = wd[7:0];
            end
        end else begin
            for (int i = 0; i < 4; i++) by[i] = wd[31 - 8*i -: 8];
        end
        return {by[0], by[1], by[2], by[3]};
    endfunction

    // Model: phase k = cycles since the accepting edge; done at phase == latency.
    always @(posedge clk) begin
        if (reset) begin
            m_phase   <= 0;
            m_lat     <= 0;
            m_rdp     <= 0;
            m_wrp     <= 0;
            m_err     <= 1'b0;
            exp_rdata <= 32'h0;
        end else begin
            if (pl_en) begin
                for (int i = 0; i < 4; i++) ref_mem[pl_addr[11:0] + 12'(i)] <= pl_data[31 - 8*i -: 8];
            end
            if (m_phase == 0) begin
                if (req) begin
                    m_phase <= 1;
                    m_err   <= ref_bad(ls_addr, ls_size);
                    m_load  <= !ls_wr;
                    m_waddr <= {ls_addr[31:2], 2'b00};
                    m_din   <= ref_store_word(ls_addr, ls_size, ls_wdata);
                    m_ld    <= ref_load(ls_addr, ls_size, ls_signed);
                    if (ref_bad(ls_addr, ls_size)) begin
                        m_lat <= 1; m_rdp <= 0; m_wrp <= 0;
                    end else if (!ls_wr) begin
                        m_lat <= 2; m_rdp <= 1; m_wrp <= 0;
                    end else if (ls_size == 2'b10) begin
                        m_lat <= 2; m_rdp <= 0; m_wrp <= 1;
                    end else begin
                        m_lat <= 3; m_rdp <= 1; m_wrp <= 2;
                    end
                end
            end else if (m_phase == m_lat) begin
                m_phase <= 0;
            end else begin
                m_phase <= m_phase + 1;
            end
            if (m_phase != 0 && m_phase == m_rdp && m_load) exp_rdata <= m_ld;
            if (m_phase != 0 && m_phase == m_wrp) begin
                for (int i = 0; i < 4; i++) ref_mem[m_waddr[11:0] + 12'(i)] <= m_din[31 - 8*i -: 8];
            end
        end
    end

    // Compare DUT outputs against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("busy",  busy,  m_phase != 0);
            chk1("done",  done,  m_phase != 0 && m_phase == m_lat);
            chk1("err",   err,   m_phase != 0 && m_phase == m_lat && m_err);
            chk1("dm_rd", dm_rd, m_phase != 0 && m_phase == m_rdp);
            chk1("dm_wr", dm_wr, m_phase != 0 && m_phase == m_wrp);
            chk1("dm_cs", dm_cs, m_phase != 0 && (m_phase == m_rdp || m_phase == m_wrp));
            chk32("ls_rdata", ls_rdata, exp_rdata);
            if (m_phase != 0 && (m_phase == m_rdp || m_phase == m_wrp))
                chk32("dm_addr", dm_addr, m_waddr);
            if (m_phase != 0 && m_phase == m_wrp)
                chk32("dm_din", dm_din, m_din);
            if (dm_rd && dm_wr) chk1("rd_wr_excl", 1'b1, 1'b0);
        end
    end

    // ---------------- activity monitors ----------------
    int          rd_cnt = 0, wr_cnt = 0, cs_cnt = 0, done_cnt = 0;
    logic [31:0] last_din = 32'h0;
    always @(posedge clk) begin
        if (dm_cs && dm_rd) rd_cnt <= rd_cnt + 1;
        if (dm_cs && dm_wr) begin
            wr_cnt   <= wr_cnt + 1;
            last_din <= dm_din;
        end
        if (dm_cs) cs_cnt <= cs_cnt + 1;
    end
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic poke(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = w;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Issue one request; lat is the cycle at which done was seen (0 = never).
    task automatic run(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic e);
        @(negedge clk); #1;
        req = 1'b1; ls_wr = wr; ls_size = sz; ls_signed = sg; ls_addr = a; ls_wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        e   = 1'b0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                e   = err;
            end
        end
        if (lat == 0) chk1("done_timeout", 1'b0, 1'b1);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic e;
        int   r0, w0, c0, d0;

        reset = 1'b1; req = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
        ls_addr = 32'h0; ls_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_cs", dm_cs, 1'b0);
        chk1("rst_rd", dm_rd, 1'b0);
        chk1("rst_wr", dm_wr, 1'b0);
        chk32("rst_rdata", ls_rdata, 32'h0);
        chk32("rst_addr", dm_addr, 32'h0);
        chk32("rst_din", dm_din, 32'h0);
        chk_en = 1'b1;

        poke(32'h10,  32'h8012_3456);
        poke(32'h20,  32'h1122_3344);
        poke(32'h30,  32'h0102_0304);
        poke(32'h40,  32'hDEAD_BEEF);
        poke(32'hFFC, 32'h0000_0000);

        // 1: sub-word loads, signed and unsigned
        run(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, e);
        chk32("lb_data", ls_rdata, 32'hFFFF_FF80);
        chk32("lb_lat", 32'(lat), 32'd2);
        chk1("lb_err", e, 1'b0);
        run(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, e);
        chk32("lbu_data", ls_rdata, 32'h0000_0080);
        run(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, e);
        chk32("lh_data", ls_rdata, 32'hFFFF_8012);
        run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, e);
        chk32("lbu3_data", ls_rdata, 32'h0000_0056);
        run(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, e);
        chk32("lhu2_data", ls_rdata, 32'h0000_3456);

        // 2: halfword store via read-modify-write
        r0 = rd_cnt; w0 = wr_cnt;
        run(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, lat, e);
        chk32("sh_lat", 32'(lat), 32'd3);
        chk32("sh_rd_cnt", 32'(rd_cnt - r0), 32'd1);
        chk32("sh_wr_cnt", 32'(wr_cnt - w0), 32'd1);
        chk32("sh_din", last_din, 32'h1122_BEEF);
        chk32("sh_mem", tb_word(32'h20), 32'h1122_BEEF);

        // 3: misaligned and illegal-size requests
        c0 = cs_cnt;
        run(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, lat, e);
        chk32("lw_mis_lat", 32'(lat), 32'd1);
        chk1("lw_mis_err", e, 1'b1);
        run(1'b1, 2'b01, 1'b0, 32'h23, 32'h0000_5555, lat, e);
        chk32("sh_mis_lat", 32'(lat), 32'd1);
        chk1("sh_mis_err", e, 1'b1);
        run(1'b0, 2'b11, 1'b0, 32'h24, 32'h0, lat, e);
        chk1("sz11_err", e, 1'b1);
        chk32("err_no_cs", 32'(cs_cnt - c0), 32'd0);
        chk32("err_mem", tb_word(32'h20), 32'h1122_BEEF);

        // 4: range boundary
        run(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFE_F00D, lat, e);
        chk32("sw_top_lat", 32'(lat), 32'd2);
        chk1("sw_top_err", e, 1'b0);
        chk32("sw_top_mem", tb_word(32'hFFC), 32'hCAFE_F00D);
        c0 = cs_cnt;
        run(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678, lat, e);
        chk1("sw_oor_err", e, 1'b1);
        chk32("sw_oor_cs", 32'(cs_cnt - c0), 32'd0);
        run(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, lat, e);
        chk32("lw_top_data", ls_rdata, 32'hCAFE_F00D);

        // 5: reset while the RMW write is pending
        @(negedge clk); #1;
        req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00; ls_signed = 1'b0;
        ls_addr = 32'h31; ls_wdata = 32'h0000_00AA;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk1("rst_mid_wr", dm_wr, 1'b0);
        chk1("rst_mid_cs", dm_cs, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_done", done, 1'b0);
        #1 reset = 1'b0;
        chk32("rst_mid_mem", tb_word(32'h30), 32'h0102_0304);
        run(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00AA, lat, e);
        chk32("sb_lat", 32'(lat), 32'd3);
        chk32("sb_mem", tb_word(32'h30), 32'h01AA_0304);

        // 6: req held high for six cycles on a word load
        d0 = done_cnt; r0 = rd_cnt;
        @(negedge clk); #1;
        req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_signed = 1'b0; ls_addr = 32'h40;
        repeat (6) @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(posedge clk);
        chk32("hold_done_cnt", 32'(done_cnt - d0), 32'd2);
        chk32("hold_rd_cnt", 32'(rd_cnt - r0), 32'd2);
        chk32("hold_data", ls_rdata, 32'hDEAD_BEEF);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
